note_stabilizer: RTL and testbench

//  Debounces the raw per-frame note codes from the pitch detector into the stable 6-bit

---
 rtl/note_stabilizer.sv | 133 +++++++++++++
 tb/tb_note_stabilizer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/note_stabilizer.sv
// Debounces raw pitch-detector note codes into a stable note for the staff writer.
// Optional octave-error suppression: define NOTE_STAB_OCTAVE_FIX_EN.
module note_stabilizer #(
  parameter int         STABLE_COUNT   = 4,
  parameter int         SILENCE_CYCLES = 9_281_250,
  parameter logic [5:0] NOTE_MAX       = 6'b110101
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        det_valid_in,
  input  logic [5:0]  det_note_in,
  input  logic [15:0] det_mag_in,
  input  logic [15:0] mag_thresh_in,
  output logic [5:0]  note_out,
  output logic        note_change_out,
  output logic        note_present_out
);

  localparam int CW = $clog2(STABLE_COUNT + 1);
  localparam int SW = $clog2(SILENCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_COUNT);
  localparam logic [SW-1:0] SIL_MAX = SW'(SILENCE_CYCLES);
  localparam logic [SW-1:0] SIL_PRE = SW'(SILENCE_CYCLES - 1);

  typedef enum logic {S_REST, S_NOTE} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [5:0]     r_note;
  logic           r_chg;
  logic [5:0]     r_cand;
  logic [CW-1:0]  r_cnt;
  logic [SW-1:0]  r_sil;

  logic [5:0]     w_s_raw;
  logic [5:0]     w_s_note;
  logic           w_match;
  logic [5:0]     w_cand_nxt;
  logic [CW-1:0]  w_cnt_nxt;
  logic           w_accept;
  logic           w_sil_clr;
  logic [5:0]     w_note_nxt;
  logic           w_chg_nxt;

  always_comb begin
    w_s_raw = det_note_in;
    if (!det_note_in[5] || (det_note_in > NOTE_MAX) ||
        (det_mag_in < mag_thresh_in))
      w_s_raw = 6'd0;
  end

`ifdef NOTE_STAB_OCTAVE_FIX_EN
  logic [4:0] w_diff;
  assign w_diff = (w_s_raw[4:0] > r_note[4:0]) ?
                  (w_s_raw[4:0] - r_note[4:0]) :
                  (r_note[4:0] - w_s_raw[4:0]);
  // A detection one octave off the held note is a detector error.
  assign w_s_note = ((r_state == S_NOTE) && w_s_raw[5] &&
                     (w_diff == 5'd12)) ? r_note : w_s_raw;
`else
  assign w_s_note = w_s_raw;
`endif

  assign w_match    = (w_s_note == r_cand);
  assign w_cand_nxt = w_match ? r_cand : w_s_note;
  assign w_cnt_nxt  = !w_match ? CW'(1) :
                      (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);
  assign w_accept   = det_valid_in && (w_cnt_nxt == CNT_MAX) &&
                      (w_cand_nxt != r_note);
  // A strobe in the threshold cycle restarts silence timing instead.
  assign w_sil_clr  = !det_valid_in && (r_sil == SIL_PRE) &&
                      (r_state == S_NOTE);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= S_REST;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (1'b1)
      w_accept:  w_state_nxt = w_cand_nxt[5] ? S_NOTE : S_REST;
      w_sil_clr: w_state_nxt = S_REST;
      default:   w_state_nxt = r_state;
    endcase
  end

  always_comb begin
    w_note_nxt = r_note;
    w_chg_nxt  = 1'b0;
    unique case (1'b1)
      w_accept: begin
        w_note_nxt = w_cand_nxt;
        w_chg_nxt  = 1'b1;
      end
      w_sil_clr: begin
        w_note_nxt = 6'd0;
        w_chg_nxt  = 1'b1;
      end
      default: begin
        w_note_nxt = r_note;
        w_chg_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_note <= 6'd0;
      r_chg  <= 1'b0;
      r_cand <= 6'd0;
      r_cnt  <= '0;
      r_sil  <= '0;
    end else begin
      r_note <= w_note_nxt;
      r_chg  <= w_chg_nxt;
      if (w_sil_clr) begin
        r_cand <= 6'd0;
        r_cnt  <= '0;
      end else if (det_valid_in) begin
        r_cand <= w_cand_nxt;
        r_cnt  <= w_cnt_nxt;
      end
      if (det_valid_in)          r_sil <= '0;
      else if (r_sil != SIL_MAX) r_sil <= r_sil + SW'(1);
    end
  end

  assign note_out         = r_note;
  assign note_change_out  = r_chg;
  assign note_present_out = r_note[5];

endmodule

// File: tb/tb_note_stabilizer.sv
// Bench for note_stabilizer: run-length reference model plus directed scenarios.
// Octave expectations follow NOTE_STAB_OCTAVE_FIX_EN.
module tb_note_stabilizer;

  localparam int SC  = 4;
  localparam int SIL = 100;
  localparam logic [5:0] A4  = 6'b101001;
  localparam logic [5:0] C5  = 6'b101100;
  localparam logic [5:0] D5  = 6'b101110;
  localparam logic [5:0] C4  = 6'b100000;
  localparam logic [5:0] OOR = 6'b111000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [5:0]  note = 6'd0;
  logic [15:0] mag = 16'd500;
  logic [15:0] thr = 16'd100;
  logic [5:0]  note_out;
  logic        chg;
  logic        pres;

  note_stabilizer #(
    .STABLE_COUNT(SC),
    .SILENCE_CYCLES(SIL)
  ) u_dut (
    .clk_in(clk),
    .rst_n_in(rst_n),
    .det_valid_in(valid),
    .det_note_in(note),
    .det_mag_in(mag),
    .mag_thresh_in(thr),
    .note_out(note_out),
    .note_change_out(chg),
    .note_present_out(pres)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int pulses = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp,
               $time);
    end
  endtask

  // Reference model: a note is taken once the last SC sanitized strobes
  // since the last clear all agree and differ from the held output.
  logic [5:0] m_out;
  logic       m_chg;
  logic [5:0] m_hist[$];
  int         m_idle;

  function automatic logic [5:0] sanit(input logic [5:0] n,
                                       input logic [15:0] m,
                                       input logic [15:0] t);
    if (n[5] == 1'b0) return 6'd0;
    if (n > 6'd53) return 6'd0;
    if (m < t) return 6'd0;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out = 6'd0;
      m_chg = 1'b0;
      m_hist.delete();
      m_idle = 0;
    end else begin
      logic [5:0] s;
      bit same;
      int a, b;
      m_chg = 1'b0;
      if (valid) begin
        s = sanit(note, mag, thr);
`ifdef NOTE_STAB_OCTAVE_FIX_EN
        a = int'(s[4:0]);
        b = int'(m_out[4:0]);
        if (m_out[5] && s[5] && ((a > b ? a - b : b - a) == 12))
          s = m_out;
`endif
        m_idle = 0;
        m_hist.push_back(s);
        if (m_hist.size() > SC) void'(m_hist.pop_front());
        same = (m_hist.size() == SC);
        foreach (m_hist[i]) if (m_hist[i] != s) same = 1'b0;
        if (same && s != m_out) begin
          m_out = s;
          m_chg = 1'b1;
        end
      end else begin
        m_idle++;
        if (m_idle == SIL && m_out[5]) begin
          m_out = 6'd0;
          m_chg = 1'b1;
          m_hist.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("cmp_note", 32'(note_out), 32'(m_out));
      check("cmp_chg", 32'(chg), 32'(m_chg));
      check("cmp_pres", 32'(pres), 32'(m_out[5]));
      if (chg) pulses++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [5:0] n, input logic [15:0] m);
    valid = 1'b1;
    note = n;
    mag = m;
    @(posedge clk);
    #1;
    valid = 1'b0;
    mag = 16'd500;
  endtask

  task automatic lock4(input logic [5:0] n);
    repeat (4) strobe(n, 16'd500);
  endtask

  int p0;

  initial begin
    #22 rst_n = 1'b1;
    @(posedge clk);
    #1;
    tick(20);
    check("rst_note", 32'(note_out), 32'd0);
    check("rst_chg", 32'(chg), 32'd0);
    check("rst_pres", 32'(pres), 32'd0);

    p0 = pulses;
    for (int i = 0; i < 4; i++) begin
      strobe(A4, 16'd500);
      if (i == 2) check("a4_early", 32'(note_out), 32'd0);
      if (i < 3) tick(9);
    end
    check("a4_lock", 32'(note_out), 32'(A4));
    check("a4_pulse", 32'(chg), 32'd1);
    tick(5);
    check("a4_once", 32'(pulses - p0), 32'd1);

    p0 = pulses;
    repeat (3) begin strobe(C5, 16'd500); tick(2); end
    strobe(D5, 16'd500);
    tick(2);
    repeat (3) begin strobe(C5, 16'd500); tick(2); end
    check("c5_hold", 32'(note_out), 32'(A4));
    check("c5_nopulse", 32'(pulses - p0), 32'd0);
    strobe(C5, 16'd500);
    check("c5_lock", 32'(note_out), 32'(C5));
    tick(2);
    check("c5_once", 32'(pulses - p0), 32'd1);

    p0 = pulses;
    lock4(A4);
    check("sil_a4", 32'(note_out), 32'(A4));
    tick(99);
    check("sil_hold", 32'(note_out), 32'(A4));
    tick(1);
    check("sil_clear", 32'(note_out), 32'd0);
    check("sil_pulse", 32'(chg), 32'd1);
    tick(150);
    check("sil_idle", 32'(pulses - p0), 32'd2);

    p0 = pulses;
    lock4(A4);
    repeat (3) strobe(OOR, 16'd500);
    check("oor_hold", 32'(note_out), 32'(A4));
    strobe(OOR, 16'd500);
    check("oor_rest", 32'(note_out), 32'd0);
    tick(2);
    check("oor_pulses", 32'(pulses - p0), 32'd2);

    p0 = pulses;
    lock4(A4);
    repeat (3) strobe(A4, 16'd50);
    check("mag_hold", 32'(note_out), 32'(A4));
    strobe(A4, 16'd50);
    check("mag_rest", 32'(note_out), 32'd0);
    tick(2);
    check("mag_pulses", 32'(pulses - p0), 32'd2);

    p0 = pulses;
    lock4(C4);
    check("c4_lock", 32'(note_out), 32'(C4));
    lock4(C5);
    tick(2);
`ifdef NOTE_STAB_OCTAVE_FIX_EN
    check("oct_note", 32'(note_out), 32'(C4));
    check("oct_pulses", 32'(pulses - p0), 32'd1);
`else
    check("oct_note", 32'(note_out), 32'(C5));
    check("oct_pulses", 32'(pulses - p0), 32'd2);
`endif

    tick(97);
    strobe(C4, 16'd500);
    check("sim_valid", 32'(pres), 32'd1);
    tick(99);
    check("sim_hold", 32'(pres), 32'd1);
    tick(1);
    check("sim_clear", 32'(pres), 32'd0);

    lock4(A4);
    repeat (3) strobe(C5, 16'd500);
    #3 rst_n = 1'b0;
    #1;
    check("rst_async", 32'(note_out), 32'd0);
    check("rst_async_chg", 32'(chg), 32'd0);
    #7 rst_n = 1'b1;
    @(posedge clk);
    #1;
    strobe(C5, 16'd500);
    check("rst_fresh", 32'(note_out), 32'd0);
    repeat (3) strobe(C5, 16'd500);
    check("rst_relock", 32'(note_out), 32'(C5));
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
